// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared PS/2 mouse protocol constants, the init command ROM
//               entry type and helpers describing the init handshake.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    localparam logic [7:0] PS2_CMD_RESET = 8'hFF;
    localparam logic [7:0] PS2_ACK       = 8'hFA;
    localparam logic [7:0] PS2_RESEND    = 8'hFE;
    localparam logic [7:0] PS2_BAT_OK    = 8'hAA;
    localparam logic [7:0] PS2_SET_RATE  = 8'hF3;
    localparam logic [7:0] PS2_GET_ID    = 8'hF2;
    localparam logic [7:0] PS2_STREAM_EN = 8'hF4;
    localparam logic [7:0] PS2_ID_WHEEL  = 8'h03;

    // One init step: command byte and number of response bytes it draws
    typedef struct packed {
        logic [7:0] cmd;
        logic [1:0] n_rsp;
    } init_entry_t;

    // Init command ROM. Without the wheel unlock the six sample-rate
    // entries are skipped, so logical index 1 maps to GET_ID.
    function automatic init_entry_t init_rom(input logic [3:0] idx, input logic wheel_en);
        init_entry_t e;
        logic [3:0]  k;
        k = idx;
        if (!wheel_en && (idx != 4'd0)) begin
            k = idx + 4'd6;
        end
        case (k)
            4'd0:                e = '{cmd: PS2_CMD_RESET, n_rsp: 2'd3};
            4'd1, 4'd3, 4'd5:    e = '{cmd: PS2_SET_RATE,  n_rsp: 2'd1};
            4'd2:                e = '{cmd: 8'hC8,         n_rsp: 2'd1};
            4'd4:                e = '{cmd: 8'h64,         n_rsp: 2'd1};
            4'd6:                e = '{cmd: 8'h50,         n_rsp: 2'd1};
            4'd7:                e = '{cmd: PS2_GET_ID,    n_rsp: 2'd2};
            default:             e = '{cmd: PS2_STREAM_EN, n_rsp: 2'd1};
        endcase
        return e;
    endfunction

    // Expected response byte number idx for a command (ID byte handled apart)
    function automatic logic [7:0] rsp_expect(input logic [7:0] cmd, input logic [1:0] idx);
        logic [7:0] v;
        v = PS2_ACK;
        if ((cmd == PS2_CMD_RESET) && (idx == 2'd1)) begin
            v = PS2_BAT_OK;
        end else if ((cmd == PS2_CMD_RESET) && (idx == 2'd2)) begin
            v = 8'h00;
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_cursor_accum.sv
`default_nettype none
// ============================================================================
// Module      : ps2_cursor_accum
// Description : Applies one movement packet to a clamped cursor position:
//               overflow squash, arithmetic scale, add, clamp to the screen.
//               All outputs register on the load strobe and hold otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_cursor_accum #(
    parameter int X_W         = 10,
    parameter int Y_W         = 10,
    parameter int X_MAX       = 639,
    parameter int Y_MAX       = 479,
    parameter int SCALE_SHIFT = 0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic [7:0]     b0,
    input  logic [7:0]     b1,
    input  logic [7:0]     b2,
    input  logic [7:0]     b3,
    input  logic           wheel_en,
    output logic [X_W-1:0] cursor_x,
    output logic [Y_W-1:0] cursor_y,
    output logic [2:0]     buttons,
    output logic [3:0]     wheel,
    output logic           pkt_valid
);

    // Two guard bits above the wider axis keep x+dx / y-dy free of overflow
    localparam int c_w = ((X_W > Y_W) ? X_W : Y_W) + 2;
    localparam logic signed [c_w-1:0] c_x_max_s = c_w'(X_MAX);
    localparam logic signed [c_w-1:0] c_y_max_s = c_w'(Y_MAX);

    logic [X_W-1:0]          r_x;
    logic [Y_W-1:0]          r_y;
    logic [2:0]              r_buttons;
    logic [3:0]              r_wheel;
    logic                    r_pkt_valid;
    logic signed [8:0]       w_dx9, w_dy9, w_dx_sh, w_dy_sh;
    logic signed [c_w-1:0]   w_dx, w_dy, w_x_sum, w_y_sum;
    logic [X_W-1:0]          w_x_nxt;
    logic [Y_W-1:0]          w_y_nxt;
    logic                    w_unused_bits;

    // Sync bit of B0 and the upper wheel nibble carry no movement information
    assign w_unused_bits = ^{b0[3], b3[7:4]};

    // Delta decode, scale, sum and clamp for the next cursor position
    always_comb begin
        w_dx9   = b0[6] ? 9'sd0 : $signed({b0[4], b1});
        w_dy9   = b0[7] ? 9'sd0 : $signed({b0[5], b2});
        w_dx_sh = w_dx9 >>> SCALE_SHIFT;
        w_dy_sh = w_dy9 >>> SCALE_SHIFT;
        w_dx    = {{(c_w-9){w_dx_sh[8]}}, w_dx_sh};
        w_dy    = {{(c_w-9){w_dy_sh[8]}}, w_dy_sh};
        // PS/2 reports +y as up while row 0 is the top of the screen
        w_x_sum = $signed({{(c_w-X_W){1'b0}}, r_x}) + w_dx;
        w_y_sum = $signed({{(c_w-Y_W){1'b0}}, r_y}) - w_dy;
        w_x_nxt = w_x_sum[X_W-1:0];
        w_y_nxt = w_y_sum[Y_W-1:0];
        if (w_x_sum[c_w-1]) begin
            w_x_nxt = '0;
        end else if (w_x_sum > c_x_max_s) begin
            w_x_nxt = X_W'(X_MAX);
        end
        if (w_y_sum[c_w-1]) begin
            w_y_nxt = '0;
        end else if (w_y_sum > c_y_max_s) begin
            w_y_nxt = Y_W'(Y_MAX);
        end
    end

    // Output registers: update together on load, hold between packets
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x         <= X_W'(X_MAX / 2);
            r_y         <= Y_W'(Y_MAX / 2);
            r_buttons   <= 3'b000;
            r_wheel     <= 4'h0;
            r_pkt_valid <= 1'b0;
        end else begin
            r_pkt_valid <= load;
            if (load) begin
                r_x       <= w_x_nxt;
                r_y       <= w_y_nxt;
                r_buttons <= b0[2:0];
                r_wheel   <= wheel_en ? b3[3:0] : 4'h0;
            end
        end
    end

    assign cursor_x  = r_x;
    assign cursor_y  = r_y;
    assign buttons   = r_buttons;
    assign wheel     = r_wheel;
    assign pkt_valid = r_pkt_valid;

endmodule
`default_nettype wire

// File: rtl/ps2_mouse_cursor.sv
`default_nettype none
// ============================================================================
// Module      : ps2_mouse_cursor
// Description : PS/2 mouse controller above the byte transceiver. Runs the
//               init handshake (reset, optional wheel unlock, stream enable),
//               assembles 3/4-byte packets with resync and gap timeout, and
//               drives a clamped cursor with buttons and wheel.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_mouse_cursor
    import ps2_pkg::*;
#(
    parameter int CLK_HZ         = 100_000_000,
    parameter int X_W            = 10,
    parameter int Y_W            = 10,
    parameter int X_MAX          = 639,
    parameter int Y_MAX          = 479,
    parameter int WHEEL_EN       = 1,
    parameter int SCALE_SHIFT    = 0,
    parameter int RSP_TIMEOUT_MS = 600,
    parameter int PKT_TIMEOUT_US = 2000
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           rx_valid,
    input  logic [7:0]     rx_data,
    output logic           tx_req,
    output logic [7:0]     tx_data,
    input  logic           tx_done,
    output logic [X_W-1:0] cursor_x,
    output logic [Y_W-1:0] cursor_y,
    output logic [2:0]     buttons,
    output logic [3:0]     wheel,
    output logic           pkt_valid,
    output logic           init_done,
    output logic           wheel_present
);

    // One shared timer; its width covers the longer (response) timeout
    localparam int                 c_cnt_w    = $clog2(CLK_HZ / 1000 * RSP_TIMEOUT_MS + 1);
    localparam logic [c_cnt_w-1:0] c_rsp_tc   = c_cnt_w'(CLK_HZ / 1000 * RSP_TIMEOUT_MS);
    localparam logic [c_cnt_w-1:0] c_pkt_tc   = c_cnt_w'(CLK_HZ / 1_000_000 * PKT_TIMEOUT_US);
    localparam logic [3:0]         c_last_idx = (WHEEL_EN != 0) ? 4'd8 : 4'd2;

    localparam logic [2:0] c_i_send     = 3'd0;
    localparam logic [2:0] c_i_wait_tx  = 3'd1;
    localparam logic [2:0] c_i_wait_rsp = 3'd2;
    localparam logic [2:0] c_s_b0       = 3'd3;
    localparam logic [2:0] c_s_b1       = 3'd4;
    localparam logic [2:0] c_s_b2       = 3'd5;
    localparam logic [2:0] c_s_b3       = 3'd6;

    logic [2:0]         r_state, w_state_nxt;
    logic [3:0]         r_idx, w_idx_nxt;
    logic [1:0]         r_rsp, w_rsp_nxt;
    logic [c_cnt_w-1:0] r_timer;
    logic               r_tx_req, w_tx_req_nxt;
    logic [7:0]         r_tx_data, w_tx_data_nxt;
    logic               r_init_done, w_init_done_nxt;
    logic               r_wheel_present, w_wheel_nxt;
    logic [7:0]         r_b0, r_b1, r_b2;
    logic               w_ok, w_restart, w_load;
    logic               w_rsp_to, w_pkt_to, w_is_id;
    logic [7:0]         w_exp, w_acc_b2;
    init_entry_t        w_entry;

    assign w_entry  = init_rom(r_idx, WHEEL_EN != 0);
    assign w_exp    = rsp_expect(w_entry.cmd, r_rsp);
    assign w_is_id  = (w_entry.cmd == PS2_GET_ID) && (r_rsp == 2'd1);
    assign w_rsp_to = (r_timer >= c_rsp_tc);
    assign w_pkt_to = (r_timer >= c_pkt_tc);
    // In a 4-byte packet B2 was stored earlier and the live byte is B3
    assign w_acc_b2 = (r_state == c_s_b3) ? r_b2 : rx_data;

    // Next-state logic for the init handshake and the stream packet framer
    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_rsp_nxt       = r_rsp;
        w_tx_req_nxt    = 1'b0;
        w_tx_data_nxt   = r_tx_data;
        w_init_done_nxt = r_init_done;
        w_wheel_nxt     = r_wheel_present;
        w_ok            = 1'b0;
        w_restart       = 1'b0;
        w_load          = 1'b0;
        case (r_state)
            c_i_send: begin
                w_tx_req_nxt  = 1'b1;
                w_tx_data_nxt = w_entry.cmd;
                w_rsp_nxt     = 2'd0;
                w_state_nxt   = c_i_wait_tx;
            end
            c_i_wait_tx: begin
                // A transceiver that never finishes would otherwise stall init
                if (tx_done) begin
                    w_state_nxt = c_i_wait_rsp;
                end else if (w_rsp_to) begin
                    w_restart = 1'b1;
                end
            end
            c_i_wait_rsp: begin
                if (rx_valid) begin
                    if (w_is_id) begin
                        w_wheel_nxt = (rx_data == PS2_ID_WHEEL);
                        w_ok        = 1'b1;
                    end else if (rx_data == w_exp) begin
                        w_ok = 1'b1;
                    end else if (rx_data == PS2_RESEND) begin
                        w_state_nxt = c_i_send;
                    end else begin
                        w_restart = 1'b1;
                    end
                end else if (w_rsp_to) begin
                    w_restart = 1'b1;
                end
            end
            c_s_b0: begin
                if (rx_valid && rx_data[3]) begin
                    w_state_nxt = c_s_b1;
                end
            end
            c_s_b1: begin
                if (rx_valid) begin
                    w_state_nxt = c_s_b2;
                end else if (w_pkt_to) begin
                    w_state_nxt = c_s_b0;
                end
            end
            c_s_b2: begin
                if (rx_valid) begin
                    w_load      = !r_wheel_present;
                    w_state_nxt = r_wheel_present ? c_s_b3 : c_s_b0;
                end else if (w_pkt_to) begin
                    w_state_nxt = c_s_b0;
                end
            end
            c_s_b3: begin
                if (rx_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = c_s_b0;
                end else if (w_pkt_to) begin
                    w_state_nxt = c_s_b0;
                end
            end
            default: begin
                w_restart = 1'b1;
            end
        endcase
        // Accepted response byte: next response, next command or stream mode
        if (w_ok) begin
            if (r_rsp == (w_entry.n_rsp - 2'd1)) begin
                if (r_idx == c_last_idx) begin
                    w_init_done_nxt = 1'b1;
                    w_state_nxt     = c_s_b0;
                end else begin
                    w_idx_nxt   = r_idx + 4'd1;
                    w_state_nxt = c_i_send;
                end
            end else begin
                w_rsp_nxt = r_rsp + 2'd1;
            end
        end
        if (w_restart) begin
            w_idx_nxt   = 4'd0;
            w_state_nxt = c_i_send;
        end
    end

    // Control registers; the timer clears on any state change or received byte
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= c_i_send;
            r_idx           <= 4'd0;
            r_rsp           <= 2'd0;
            r_timer         <= '0;
            r_tx_req        <= 1'b0;
            r_tx_data       <= 8'h00;
            r_init_done     <= 1'b0;
            r_wheel_present <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_idx           <= w_idx_nxt;
            r_rsp           <= w_rsp_nxt;
            r_tx_req        <= w_tx_req_nxt;
            r_tx_data       <= w_tx_data_nxt;
            r_init_done     <= w_init_done_nxt;
            r_wheel_present <= w_wheel_nxt;
            if ((w_state_nxt != r_state) || rx_valid) begin
                r_timer <= '0;
            end else if (r_timer != {c_cnt_w{1'b1}}) begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

    // Packet byte capture for B0..B2 while framing
    always_ff @(posedge clk) begin
        if (reset) begin
            r_b0 <= 8'h00;
            r_b1 <= 8'h00;
            r_b2 <= 8'h00;
        end else if (rx_valid) begin
            if ((r_state == c_s_b0) && rx_data[3]) begin
                r_b0 <= rx_data;
            end
            if (r_state == c_s_b1) begin
                r_b1 <= rx_data;
            end
            if (r_state == c_s_b2) begin
                r_b2 <= rx_data;
            end
        end
    end

    ps2_cursor_accum #(
        .X_W         (X_W),
        .Y_W         (Y_W),
        .X_MAX       (X_MAX),
        .Y_MAX       (Y_MAX),
        .SCALE_SHIFT (SCALE_SHIFT)
    ) u_accum (
        .clk       (clk),
        .reset     (reset),
        .load      (w_load),
        .b0        (r_b0),
        .b1        (r_b1),
        .b2        (w_acc_b2),
        .b3        (rx_data),
        .wheel_en  (r_wheel_present),
        .cursor_x  (cursor_x),
        .cursor_y  (cursor_y),
        .buttons   (buttons),
        .wheel     (wheel),
        .pkt_valid (pkt_valid)
    );

    assign tx_req        = r_tx_req;
    assign tx_data       = r_tx_data;
    assign init_done     = r_init_done;
    assign wheel_present = r_wheel_present;

endmodule
`default_nettype wire

// File: tb/tb_ps2_mouse_cursor.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_mouse_cursor
// Description : Directed self-checking bench for ps2_mouse_cursor: init
//               handshake, resend/restart, packet math, clamping, wheel,
//               resync, packet timeout and reset mid-packet.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_mouse_cursor;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_done = 1'b0;
    logic       tx_req;
    logic [7:0] tx_data;
    logic [9:0] cursor_x, cursor_y;
    logic [2:0] buttons;
    logic [3:0] wheel;
    logic       pkt_valid, init_done, wheel_present;

    int checks = 0;
    int failures = 0;
    int pkt_cnt = 0;

    // 1 MHz nominal clock: 1 us per cycle, 1000-cycle response timeout,
    // 20-cycle packet gap timeout
    ps2_mouse_cursor #(
        .CLK_HZ(1_000_000), .X_W(10), .Y_W(10), .X_MAX(639), .Y_MAX(479),
        .WHEEL_EN(1), .SCALE_SHIFT(0), .RSP_TIMEOUT_MS(1), .PKT_TIMEOUT_US(20)
    ) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_req(tx_req), .tx_data(tx_data), .tx_done(tx_done),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .buttons(buttons),
        .wheel(wheel), .pkt_valid(pkt_valid), .init_done(init_done),
        .wheel_present(wheel_present)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pkt_valid === 1'b1) pkt_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1; rx_valid = 1'b0; tx_done = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_pkt3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        send_byte(a); send_byte(b); send_byte(c);
    endtask

    // Wait for a tx_req pulse, capture the byte, then acknowledge with tx_done
    task automatic wait_tx(input int max_cyc, output logic [7:0] d, output bit ok);
        ok = 1'b0; d = 8'h00;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            @(negedge clk);
            if (tx_req === 1'b1) begin ok = 1'b1; d = tx_data; end
        end
        if (ok) begin
            repeat (2) @(negedge clk);
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
        end
    endtask

    // Play the device side of init from command index start; errs tallies
    // missing or wrong command bytes
    task automatic run_init(input int start, input logic [7:0] id, output int errs);
        logic [7:0] seq [0:8];
        logic [7:0] d;
        bit         ok;
        seq = '{8'hFF, 8'hF3, 8'hC8, 8'hF3, 8'h64, 8'hF3, 8'h50, 8'hF2, 8'hF4};
        errs = 0;
        for (int i = start; i < 9; i++) begin
            wait_tx(64, d, ok);
            if (!ok || d !== seq[i]) errs++;
            send_byte(8'hFA);
            if (i == 0) begin send_byte(8'hAA); send_byte(8'h00); end
            if (i == 7) send_byte(id);
        end
    endtask

    task automatic test_reset;
        logic [7:0] d;
        bit         ok;
        @(negedge clk); reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({tx_req, tx_data, buttons, wheel, pkt_valid, init_done, wheel_present} !== 17'd0) begin
            failures++;
            $display("FAIL reset_flags: got req=%0b data=%h btn=%b whl=%h pv=%0b id=%0b wp=%0b expected all zero",
                     tx_req, tx_data, buttons, wheel, pkt_valid, init_done, wheel_present);
        end
        checks++;
        if (cursor_x !== 10'd319 || cursor_y !== 10'd239) begin
            failures++;
            $display("FAIL reset_cursor: got (%0d,%0d) expected (319,239)", cursor_x, cursor_y);
        end
        reset = 1'b0;
        wait_tx(8, d, ok);
        checks++;
        if (!ok || d !== 8'hFF) begin
            failures++;
            $display("FAIL reset_first_tx: got ok=%0b data=%h expected FF", ok, d);
        end
    endtask

    task automatic test_init_wheel;
        int errs;
        do_reset();
        run_init(0, 8'h03, errs);
        checks++;
        if (errs !== 0) begin
            failures++;
            $display("FAIL init_sequence: got %0d bad commands expected 0", errs);
        end
        checks++;
        if (init_done !== 1'b1 || wheel_present !== 1'b1) begin
            failures++;
            $display("FAIL init_flags: got done=%0b wheel=%0b expected 1 1", init_done, wheel_present);
        end
    endtask

    task automatic test_resend;
        logic [7:0] d, d2;
        bit         ok, ok2;
        int         errs;
        do_reset();
        wait_tx(64, d, ok);
        send_byte(8'hFA); send_byte(8'hAA); send_byte(8'h00);
        wait_tx(64, d, ok);
        send_byte(8'hFE);
        wait_tx(64, d2, ok2);
        checks++;
        if (!ok || !ok2 || d !== 8'hF3 || d2 !== 8'hF3) begin
            failures++;
            $display("FAIL resend_cmd: got %h then %h expected F3 then F3", d, d2);
        end
        send_byte(8'hFA);
        run_init(2, 8'h03, errs);
        checks++;
        if (errs !== 0 || init_done !== 1'b1) begin
            failures++;
            $display("FAIL resend_continue: got errs=%0d done=%0b expected 0 1", errs, init_done);
        end
    endtask

    task automatic test_restart;
        logic [7:0] d;
        bit         ok;
        do_reset();
        wait_tx(64, d, ok);
        send_byte(8'hFA); send_byte(8'hAA); send_byte(8'h00);
        wait_tx(64, d, ok);
        send_byte(8'hFC);
        wait_tx(64, d, ok);
        checks++;
        if (!ok || d !== 8'hFF) begin
            failures++;
            $display("FAIL restart_mismatch: got ok=%0b data=%h expected FF", ok, d);
        end
        // No reply at all: the response timeout must restart the list
        wait_tx(1200, d, ok);
        checks++;
        if (!ok || d !== 8'hFF) begin
            failures++;
            $display("FAIL restart_timeout: got ok=%0b data=%h expected FF", ok, d);
        end
    endtask

    task automatic test_packet_basic;
        int errs, base;
        do_reset();
        run_init(0, 8'h00, errs);
        checks++;
        if (errs !== 0 || init_done !== 1'b1 || wheel_present !== 1'b0) begin
            failures++;
            $display("FAIL init_noid: got errs=%0d done=%0b wheel=%0b expected 0 1 0", errs, init_done, wheel_present);
        end
        base = pkt_cnt;
        send_pkt3(8'h09, 8'h05, 8'h03);
        checks++;
        if (pkt_valid !== 1'b1 || cursor_x !== 10'd324 || cursor_y !== 10'd236 ||
            buttons !== 3'b001 || wheel !== 4'h0) begin
            failures++;
            $display("FAIL pkt_basic: got pv=%0b (%0d,%0d) btn=%b whl=%h expected 1 (324,236) 001 0",
                     pkt_valid, cursor_x, cursor_y, buttons, wheel);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (pkt_valid !== 1'b0 || pkt_cnt - base !== 1 || cursor_x !== 10'd324) begin
            failures++;
            $display("FAIL pkt_hold: got pv=%0b pulses=%0d x=%0d expected 0 1 324", pkt_valid, pkt_cnt - base, cursor_x);
        end
    endtask

    task automatic test_clamp;
        send_pkt3(8'h18, 8'h00, 8'hFF);
        send_pkt3(8'h18, 8'h00, 8'hFF);
        send_pkt3(8'h28, 8'h02, 8'hFE);
        checks++;
        if (cursor_x !== 10'd2 || cursor_y !== 10'd2) begin
            failures++;
            $display("FAIL clamp_setup: got (%0d,%0d) expected (2,2)", cursor_x, cursor_y);
        end
        send_pkt3(8'h38, 8'hF6, 8'h0A);
        checks++;
        if (cursor_x !== 10'd0 || cursor_y !== 10'd248 || buttons !== 3'b000) begin
            failures++;
            $display("FAIL clamp_low: got (%0d,%0d) btn=%b expected (0,248) 000", cursor_x, cursor_y, buttons);
        end
        send_pkt3(8'h08, 8'hFF, 8'hF6);
        send_pkt3(8'h08, 8'hFF, 8'h00);
        send_pkt3(8'h08, 8'h80, 8'h00);
        checks++;
        if (cursor_x !== 10'd638 || cursor_y !== 10'd2) begin
            failures++;
            $display("FAIL clamp_setup2: got (%0d,%0d) expected (638,2)", cursor_x, cursor_y);
        end
        send_pkt3(8'h08, 8'h7F, 8'h7F);
        checks++;
        if (cursor_x !== 10'd639 || cursor_y !== 10'd0) begin
            failures++;
            $display("FAIL clamp_high: got (%0d,%0d) expected (639,0)", cursor_x, cursor_y);
        end
    endtask

    task automatic test_overflow;
        send_pkt3(8'h68, 8'hF0, 8'hF0);
        checks++;
        if (cursor_x !== 10'd639 || cursor_y !== 10'd16) begin
            failures++;
            $display("FAIL ovf_x: got (%0d,%0d) expected (639,16)", cursor_x, cursor_y);
        end
        send_pkt3(8'h98, 8'hF0, 8'hF0);
        checks++;
        if (cursor_x !== 10'd623 || cursor_y !== 10'd16) begin
            failures++;
            $display("FAIL ovf_y: got (%0d,%0d) expected (623,16)", cursor_x, cursor_y);
        end
    endtask

    task automatic test_wheel_packet;
        int errs, base;
        do_reset();
        run_init(0, 8'h03, errs);
        base = pkt_cnt;
        send_byte(8'h00);
        send_pkt3(8'h08, 8'h00, 8'h00);
        checks++;
        if (pkt_valid !== 1'b0) begin
            failures++;
            $display("FAIL wheel_len: got pv=%0b after 3rd byte expected 0", pkt_valid);
        end
        send_byte(8'h0F);
        checks++;
        if (pkt_valid !== 1'b1 || wheel !== 4'hF || cursor_x !== 10'd319 || cursor_y !== 10'd239) begin
            failures++;
            $display("FAIL wheel_pkt: got pv=%0b whl=%h (%0d,%0d) expected 1 F (319,239)",
                     pkt_valid, wheel, cursor_x, cursor_y);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (pkt_cnt - base !== 1) begin
            failures++;
            $display("FAIL wheel_count: got %0d pulses expected 1", pkt_cnt - base);
        end
    endtask

    task automatic test_pkt_timeout;
        int errs, base;
        do_reset();
        run_init(0, 8'h00, errs);
        base = pkt_cnt;
        send_byte(8'h08); send_byte(8'h01);
        repeat (25) @(negedge clk);
        send_pkt3(8'h08, 8'h02, 8'h00);
        repeat (2) @(negedge clk);
        checks++;
        if (pkt_cnt - base !== 1 || cursor_x !== 10'd321 || cursor_y !== 10'd239) begin
            failures++;
            $display("FAIL pkt_timeout: got pulses=%0d (%0d,%0d) expected 1 (321,239)",
                     pkt_cnt - base, cursor_x, cursor_y);
        end
    endtask

    task automatic test_reset_mid_packet;
        logic [7:0] d;
        bit         ok;
        send_byte(8'h0B); send_byte(8'h7F);
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        checks++;
        if (cursor_x !== 10'd319 || cursor_y !== 10'd239 || init_done !== 1'b0 ||
            buttons !== 3'b000 || pkt_valid !== 1'b0 || tx_req !== 1'b0) begin
            failures++;
            $display("FAIL midreset_outputs: got (%0d,%0d) done=%0b btn=%b pv=%0b req=%0b expected (319,239) 0 000 0 0",
                     cursor_x, cursor_y, init_done, buttons, pkt_valid, tx_req);
        end
        reset = 1'b0;
        wait_tx(8, d, ok);
        checks++;
        if (!ok || d !== 8'hFF) begin
            failures++;
            $display("FAIL midreset_tx: got ok=%0b data=%h expected FF", ok, d);
        end
    endtask

    initial begin
        test_reset();
        test_init_wheel();
        test_resend();
        test_restart();
        test_packet_basic();
        test_clamp();
        test_overflow();
        test_wheel_packet();
        test_pkt_timeout();
        test_reset_mid_packet();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
